// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of mem_access_ctrl: address/data/request out, read data and
// completion strobe back. master = controller, slave = memory.
`timescale 1ns/1ps
interface mem_access_ctrl_if;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic        memReq;
  logic        memWr;
  logic [15:0] memRData;
  logic        memAck;

  modport master (
    output memAddr, memWData, memReq, memWr,
    input  memRData, memAck
  );

  modport slave (
    input  memAddr, memWData, memReq, memWr,
    output memRData, memAck
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 style MAR/MDR memory access controller (IDLE -> ACCESS -> DONE).
// Optional ACCESS timeout with sticky memErr is enabled by defining MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             MARMuxOut,
  input  logic                    ldMAR,
  input  logic [15:0]             busIn,
  input  logic                    ldMDR,
  input  logic                    memEN,
  input  logic                    memWE,
  output logic [15:0]             MAR,
  output logic [15:0]             MDR,
  output logic                    memReady,
  output logic                    busy,
  output logic                    memErr,
  mem_access_ctrl_if.master       mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state;
  state_t stateNext;
  logic   memWrQ;
  logic   accept;
  logic   timeoutHit;

  assign accept = (state == IDLE) && memEN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (memEN) stateNext = ACCESS;
      ACCESS:  if (mem.memAck || timeoutHit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem.memReq = (state == ACCESS);
    memReady   = (state == DONE);
    busy       = (state != IDLE);
  end

  // Loads are only honoured in IDLE; read data lands on the completing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MAR    <= '0;
      MDR    <= '0;
      memWrQ <= 1'b0;
    end else if (state == IDLE) begin
      if (ldMAR) MAR <= MARMuxOut;
      if (ldMDR) MDR <= busIn;
      if (memEN) memWrQ <= memWE;
    end else if ((state == ACCESS) && mem.memAck && !memWrQ) begin
      MDR <= mem.memRData;
    end
  end

  assign mem.memAddr  = MAR;
  assign mem.memWData = MDR;
  assign mem.memWr    = memWrQ;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] toCount;
  logic            errQ;

  // Expiry is the last ACCESS cycle without memAck; an ack on that cycle wins.
  assign timeoutHit = (state == ACCESS) && !mem.memAck &&
                      (toCount == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toCount <= '0;
    end else if ((state == ACCESS) && !mem.memAck && !timeoutHit) begin
      toCount <= toCount + 1'b1;
    end else begin
      toCount <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errQ <= 1'b0;
    end else if (accept) begin
      errQ <= 1'b0;
    end else if (timeoutHit) begin
      errQ <= 1'b1;
    end
  end

  assign memErr = errQ;
`else
  assign timeoutHit = 1'b0;
  assign memErr     = 1'b0;
`endif

endmodule
